// File: rtl/adc_spi_sampler.sv
// adc_spi_sampler
//   Periodically reads one 16-bit sample from an external SPI ADC (mode 0,
//   MSB first) and presents it on data_o with a one-cycle data_av_sync strobe.
//   Owns chip-select / serial-clock generation and the sample-rate timer, and
//   flags conversion requests dropped because a conversion is still running.
//
// Parameters
//   CLK_DIV        SCLK half-period in clk_i cycles (>=1, >=3 with MISO sync)
//   SAMPLE_PERIOD  clk_i cycles between conversion requests (>=2)
//
// Ports
//   clk_i         in   single clock, rising edge
//   rst_i         in   synchronous, active-high reset
//   enable_i      in   runs the sample-rate timer
//   adc_miso_i    in   ADC serial data
//   adc_cs_n_o    out  ADC chip select, active-low
//   adc_sclk_o    out  ADC serial clock, idles low
//   data_o        out  last completed sample
//   data_av_sync  out  one-cycle strobe, data_o is new in the same cycle
//   busy_o        out  FSM not in IDLE
//   overrun_o     out  sticky dropped-request flag
//
// Build option
//   ADC_SPI_SAMPLER_MISO_SYNC_EN  routes adc_miso_i through a 2-flop
//   synchronizer; capture then happens 2 cycles after each SCLK rise.
//
// state     | meaning
// ----------+----------------------------------------------------
// IDLE      | waiting for a timer tick, CS high, SCLK low
// CS_SETUP  | CS low for CLK_DIV cycles before the first SCLK rise
// SHIFT     | 16 SCLK periods, one bit captured per period
// CS_HOLD   | CS still low, SCLK low, for CLK_DIV cycles
// DONE      | CS high, data_o loaded, strobe high for one cycle

module adc_spi_sampler #(
  parameter int CLK_DIV       = 4,
  parameter int SAMPLE_PERIOD = 200
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        enable_i,
  input  logic        adc_miso_i,
  output logic        adc_cs_n_o,
  output logic        adc_sclk_o,
  output logic [15:0] data_o,
  output logic        data_av_sync,
  output logic        busy_o,
  output logic        overrun_o
);

  localparam int TMR_W = $clog2(SAMPLE_PERIOD);
  localparam int DIV_W = $clog2(CLK_DIV + 1);

  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(SAMPLE_PERIOD - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_CS_SETUP = 3'd1;
  localparam logic [2:0] ST_SHIFT    = 3'd2;
  localparam logic [2:0] ST_CS_HOLD  = 3'd3;
  localparam logic [2:0] ST_DONE     = 3'd4;

  logic [2:0]       state;
  logic [TMR_W-1:0] timer;
  logic             tick;
  logic [DIV_W-1:0] div_cnt;
  logic [3:0]       bit_cnt;
  logic [15:0]      shift_reg;
  logic             capture;
  logic             capture_bit;

  // Sample-rate timer: counts up while enabled, tick on the last count.
  always_ff @(posedge clk_i) begin
    if (rst_i || !enable_i) begin
      timer <= '0;
    end else if (timer == TMR_LAST) begin
      timer <= '0;
    end else begin
      timer <= timer + TMR_W'(1);
    end
  end

  assign tick = enable_i && (timer == TMR_LAST);

  // A tick outside IDLE is dropped; the running conversion is untouched.
  always_ff @(posedge clk_i) begin
    if (rst_i || !enable_i) begin
      overrun_o <= 1'b0;
    end else if (tick && (state != ST_IDLE)) begin
      overrun_o <= 1'b1;
    end
  end

`ifdef ADC_SPI_SAMPLER_MISO_SYNC_EN
  // div_cnt reloads to CLK_DIV-1 on the SCLK rise, so CLK_DIV-2 is seen two
  // edges later; the synchronized bit then holds the value present at the rise.
  localparam logic [DIV_W-1:0] DIV_CAP = DIV_W'(CLK_DIV - 2);

  logic [1:0] miso_sync;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      miso_sync <= 2'b00;
    end else begin
      miso_sync <= {miso_sync[0], adc_miso_i};
    end
  end

  assign capture     = (state == ST_SHIFT) && adc_sclk_o && (div_cnt == DIV_CAP);
  assign capture_bit = miso_sync[1];
`else
  // Capture on the same edge that drives SCLK 0->1 (first rise leaves CS_SETUP).
  assign capture     = (div_cnt == '0) &&
                       ((state == ST_CS_SETUP) || ((state == ST_SHIFT) && !adc_sclk_o));
  assign capture_bit = adc_miso_i;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      shift_reg <= '0;
    end else if (capture) begin
      shift_reg <= {shift_reg[14:0], capture_bit};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= ST_IDLE;
      div_cnt      <= '0;
      bit_cnt      <= '0;
      adc_cs_n_o   <= 1'b1;
      adc_sclk_o   <= 1'b0;
      data_o       <= '0;
      data_av_sync <= 1'b0;
    end else begin
      data_av_sync <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (tick) begin
            state      <= ST_CS_SETUP;
            adc_cs_n_o <= 1'b0;
            div_cnt    <= DIV_LAST;
            bit_cnt    <= '0;
          end
        end
        ST_CS_SETUP: begin
          if (div_cnt == '0) begin
            state      <= ST_SHIFT;
            adc_sclk_o <= 1'b1;
            div_cnt    <= DIV_LAST;
          end else begin
            div_cnt <= div_cnt - DIV_W'(1);
          end
        end
        ST_SHIFT: begin
          if (div_cnt == '0) begin
            div_cnt    <= DIV_LAST;
            adc_sclk_o <= ~adc_sclk_o;
            if (adc_sclk_o) begin
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd15) begin
                state <= ST_CS_HOLD;
              end
            end
          end else begin
            div_cnt <= div_cnt - DIV_W'(1);
          end
        end
        ST_CS_HOLD: begin
          if (div_cnt == '0) begin
            state        <= ST_DONE;
            adc_cs_n_o   <= 1'b1;
            data_o       <= shift_reg;
            data_av_sync <= 1'b1;
          end else begin
            div_cnt <= div_cnt - DIV_W'(1);
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy_o = (state != ST_IDLE);

endmodule

// File: tb/tb_adc_spi_sampler.sv
module tb_adc_spi_sampler;

`ifdef ADC_SPI_SAMPLER_MISO_SYNC_EN
  localparam int CD = 3;
`else
  localparam int CD = 4;
`endif
  localparam int SP_M = 200;
  localparam int SP_O = 100;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en_m = 1'b0;
  logic en_o = 1'b0;
  logic miso_m = 1'b0;
  logic miso_o = 1'b0;

  logic        cs_n_m, sclk_m, strobe_m, busy_m, ovr_m;
  logic [15:0] data_m;
  logic        cs_n_o, sclk_o, strobe_o, busy_o, ovr_o;
  logic [15:0] data_o;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  logic [15:0] adc_q_m[$];
  logic [15:0] adc_q_o[$];
  logic [15:0] exp_q_m[$];
  logic [15:0] exp_q_o[$];
  logic [15:0] adc_sh_m = 16'h0;
  logic [15:0] adc_sh_o = 16'h0;

  adc_spi_sampler #(.CLK_DIV(CD), .SAMPLE_PERIOD(SP_M)) u_dut (
    .clk_i(clk), .rst_i(rst), .enable_i(en_m), .adc_miso_i(miso_m),
    .adc_cs_n_o(cs_n_m), .adc_sclk_o(sclk_m), .data_o(data_m),
    .data_av_sync(strobe_m), .busy_o(busy_m), .overrun_o(ovr_m)
  );

  adc_spi_sampler #(.CLK_DIV(CD), .SAMPLE_PERIOD(SP_O)) u_ovr (
    .clk_i(clk), .rst_i(rst), .enable_i(en_o), .adc_miso_i(miso_o),
    .adc_cs_n_o(cs_n_o), .adc_sclk_o(sclk_o), .data_o(data_o),
    .data_av_sync(strobe_o), .busy_o(busy_o), .overrun_o(ovr_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ADC models: next word loaded at CS fall (MSB out), shift on SCLK fall.
  always @(negedge cs_n_m) begin
    adc_sh_m = (adc_q_m.size() > 0) ? adc_q_m.pop_front() : 16'h0;
    miso_m = adc_sh_m[15];
  end
  always @(negedge sclk_m) begin
    if (!cs_n_m) begin
      adc_sh_m = adc_sh_m << 1;
      miso_m = adc_sh_m[15];
    end
  end
  always @(negedge cs_n_o) begin
    adc_sh_o = (adc_q_o.size() > 0) ? adc_q_o.pop_front() : 16'h0;
    miso_o = adc_sh_o[15];
  end
  always @(negedge sclk_o) begin
    if (!cs_n_o) begin
      adc_sh_o = adc_sh_o << 1;
      miso_o = adc_sh_o[15];
    end
  end

  // Expected {busy, cs_n, sclk, strobe} at offset off from the CS-fall cycle.
  function automatic logic [3:0] pin_model(input int off);
    if (off < 0 || off > 33 * CD) return 4'b0100;
    if (off == 33 * CD) return 4'b1101;
    if (off >= CD && (((off - CD) / CD) % 2) == 0) return 4'b1010;
    return 4'b1000;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if ({cs_n_m, sclk_m, data_m, strobe_m, busy_m, ovr_m} !== {1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_main got %b exp %b", {cs_n_m, sclk_m, data_m, strobe_m, busy_m, ovr_m}, {1'b1, 1'b0, 16'h0, 3'b000});
    end
    vectors++;
    if ({cs_n_o, sclk_o, data_o, strobe_o, busy_o, ovr_o} !== {1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_ovr got %b exp %b", {cs_n_o, sclk_o, data_o, strobe_o, busy_o, ovr_o}, {1'b1, 1'b0, 16'h0, 3'b000});
    end
    rst = 1'b0;
  endtask

  task automatic test_single();
    int s, off, n_strobe;
    logic [3:0] exp;
    logic [15:0] w;
    adc_q_m.push_back(16'hA5C3);
    exp_q_m.push_back(16'hA5C3);
    @(negedge clk);
    en_m = 1'b1;
    s = cyc + SP_M;
    n_strobe = 0;
    while (cyc < s + 33 * CD + 4) begin
      @(negedge clk);
      off = cyc - s;
      exp = pin_model(off);
      vectors++;
      if ({busy_m, cs_n_m, sclk_m, strobe_m} !== exp) begin
        miscompares++;
        $display("FAIL single_pins off=%0d got %b exp %b", off, {busy_m, cs_n_m, sclk_m, strobe_m}, exp);
      end
      if (strobe_m === 1'b1) begin
        n_strobe++;
        w = (exp_q_m.size() > 0) ? exp_q_m.pop_front() : 16'hxxxx;
        vectors++;
        if (data_m !== w) begin
          miscompares++;
          $display("FAIL single_data got %h exp %h", data_m, w);
        end
      end
    end
    vectors++;
    if (data_m !== 16'hA5C3 || n_strobe != 1) begin
      miscompares++;
      $display("FAIL single_hold data=%h strobes=%0d exp data=a5c3 strobes=1", data_m, n_strobe);
    end
    en_m = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [15:0] words[5];
    int s, off, last, n_strobe;
    logic [3:0] exp;
    logic [15:0] w;
    words = '{16'h0001, 16'hFFFF, 16'h0001, 16'h8001, 16'h0000};
    words[4] = 16'($urandom) | 16'h0100;
    for (int i = 0; i < 5; i++) begin
      adc_q_m.push_back(words[i]);
      exp_q_m.push_back(words[i]);
    end
    @(negedge clk);
    en_m = 1'b1;
    s = cyc + SP_M;
    last = -1;
    n_strobe = 0;
    while (cyc < s + 4 * SP_M + 33 * CD + 3) begin
      @(negedge clk);
      off = cyc - s;
      if (off >= 0) off = off % SP_M;
      exp = pin_model(off);
      vectors++;
      if ({busy_m, cs_n_m, sclk_m, strobe_m, ovr_m} !== {exp, 1'b0}) begin
        miscompares++;
        $display("FAIL b2b_pins cyc=%0d off=%0d got %b exp %b", cyc, off, {busy_m, cs_n_m, sclk_m, strobe_m, ovr_m}, {exp, 1'b0});
      end
      if (strobe_m === 1'b1) begin
        n_strobe++;
        w = (exp_q_m.size() > 0) ? exp_q_m.pop_front() : 16'hxxxx;
        vectors++;
        if (data_m !== w) begin
          miscompares++;
          $display("FAIL b2b_data strobe=%0d got %h exp %h", n_strobe, data_m, w);
        end
        if (last >= 0) begin
          vectors++;
          if (cyc - last != SP_M) begin
            miscompares++;
            $display("FAIL b2b_spacing got %0d exp %0d", cyc - last, SP_M);
          end
        end
        last = cyc;
      end
    end
    vectors++;
    if (n_strobe != 5) begin
      miscompares++;
      $display("FAIL b2b_count got %0d exp 5", n_strobe);
    end
    en_m = 1'b0;
  endtask

  task automatic test_overrun();
    int e0, s, off, n_strobe;
    logic [3:0] exp;
    logic [15:0] w;
    logic exp_ovr;
    for (int i = 0; i < 2; i++) begin
      w = 16'($urandom);
      adc_q_o.push_back(w);
      exp_q_o.push_back(w);
    end
    @(negedge clk);
    en_o = 1'b1;
    e0 = cyc;
    s = e0 + SP_O;
    n_strobe = 0;
    while (cyc < s + 2 * SP_O + 33 * CD + 3) begin
      @(negedge clk);
      off = cyc - s;
      if (off >= 0) off = off % (2 * SP_O);
      exp = pin_model(off);
      exp_ovr = (cyc >= e0 + 2 * SP_O);
      vectors++;
      if ({busy_o, cs_n_o, sclk_o, strobe_o, ovr_o} !== {exp, exp_ovr}) begin
        miscompares++;
        $display("FAIL ovr_pins cyc=%0d off=%0d got %b exp %b", cyc, off, {busy_o, cs_n_o, sclk_o, strobe_o, ovr_o}, {exp, exp_ovr});
      end
      if (strobe_o === 1'b1) begin
        n_strobe++;
        w = (exp_q_o.size() > 0) ? exp_q_o.pop_front() : 16'hxxxx;
        vectors++;
        if (data_o !== w) begin
          miscompares++;
          $display("FAIL ovr_data got %h exp %h", data_o, w);
        end
      end
    end
    en_o = 1'b0;
    @(negedge clk);
    vectors++;
    if (ovr_o !== 1'b0 || n_strobe != 2) begin
      miscompares++;
      $display("FAIL ovr_clear overrun=%b strobes=%0d exp overrun=0 strobes=2", ovr_o, n_strobe);
    end
  endtask

  task automatic test_reset_mid_shift();
    int s, off, n_strobe;
    logic [3:0] exp;
    logic [15:0] w1, w2, w;
    w1 = 16'($urandom);
    w2 = 16'($urandom);
    adc_q_m.push_back(w1);
    adc_q_m.push_back(w2);
    exp_q_m.push_back(w2);
    @(negedge clk);
    en_m = 1'b1;
    s = cyc + SP_M;
    off = cyc - s;
    while (off < 9 * CD) begin
      @(negedge clk);
      off = cyc - s;
      exp = pin_model(off);
      vectors++;
      if ({busy_m, cs_n_m, sclk_m, strobe_m} !== exp) begin
        miscompares++;
        $display("FAIL rstmid_pre off=%0d got %b exp %b", off, {busy_m, cs_n_m, sclk_m, strobe_m}, exp);
      end
    end
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if ({cs_n_m, sclk_m, data_m, strobe_m, busy_m} !== {1'b1, 1'b0, 16'h0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL rstmid_abort got %b exp %b", {cs_n_m, sclk_m, data_m, strobe_m, busy_m}, {1'b1, 1'b0, 16'h0, 2'b00});
    end
    rst = 1'b0;
    s = cyc + SP_M;
    n_strobe = 0;
    while (cyc < s + 33 * CD + 3) begin
      @(negedge clk);
      off = cyc - s;
      exp = pin_model(off);
      vectors++;
      if ({busy_m, cs_n_m, sclk_m, strobe_m} !== exp) begin
        miscompares++;
        $display("FAIL rstmid_post off=%0d got %b exp %b", off, {busy_m, cs_n_m, sclk_m, strobe_m}, exp);
      end
      if (strobe_m === 1'b1) begin
        n_strobe++;
        w = (exp_q_m.size() > 0) ? exp_q_m.pop_front() : 16'hxxxx;
        vectors++;
        if (data_m !== w) begin
          miscompares++;
          $display("FAIL rstmid_data got %h exp %h", data_m, w);
        end
      end
    end
    vectors++;
    if (n_strobe != 1) begin
      miscompares++;
      $display("FAIL rstmid_count got %0d exp 1", n_strobe);
    end
    en_m = 1'b0;
  endtask

  task automatic test_enable_drop();
    int s, off, n_strobe;
    logic [3:0] exp;
    logic [15:0] w;
    w = 16'($urandom);
    adc_q_m.push_back(w);
    exp_q_m.push_back(w);
    @(negedge clk);
    en_m = 1'b1;
    s = cyc + SP_M;
    n_strobe = 0;
    while (cyc < s + 33 * CD + SP_M + 20) begin
      @(negedge clk);
      off = cyc - s;
      exp = pin_model(off);
      vectors++;
      if ({busy_m, cs_n_m, sclk_m, strobe_m} !== exp) begin
        miscompares++;
        $display("FAIL endrop_pins off=%0d got %b exp %b", off, {busy_m, cs_n_m, sclk_m, strobe_m}, exp);
      end
      if (strobe_m === 1'b1) begin
        n_strobe++;
        w = (exp_q_m.size() > 0) ? exp_q_m.pop_front() : 16'hxxxx;
        vectors++;
        if (data_m !== w) begin
          miscompares++;
          $display("FAIL endrop_data got %h exp %h", data_m, w);
        end
      end
      if (off == 10 * CD) en_m = 1'b0;
    end
    vectors++;
    if (n_strobe != 1 || exp_q_m.size() != 0) begin
      miscompares++;
      $display("FAIL endrop_count strobes=%0d left=%0d exp strobes=1 left=0", n_strobe, exp_q_m.size());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overrun();
    test_reset_mid_shift();
    test_enable_drop();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached at cyc=%0d", cyc);
    $fatal(1);
  end

endmodule

// File: doc/adc_spi_sampler.md
# adc_spi_sampler

- Front-end stage that periodically reads one 16-bit sample from an external SPI ADC (mode 0, MSB first).
- Presents the sample on `data_o` with a one-cycle `data_av_sync` strobe, so both connect directly to the median filter's `data_i` / `data_av_sync` inputs.
- Owns ADC chip-select and serial-clock generation and the sample-rate timer.
- Flags conversion requests that are dropped because the previous conversion is still running.

## Interface
- `CLK_DIV`, default 4: SCLK half-period in `clk_i` cycles. Legal range is ≥1, or ≥3 when the MISO synchronizer (see Configuration) is compiled in.
- `SAMPLE_PERIOD`, default 200: `clk_i` cycles between conversion requests. Must be ≥2.
- `clk_i`  in  1: single clock; all logic is on its rising edge.
- `rst_i`  in  1: reset, synchronous, active-high.
- `enable_i`  in  1: runs the sample-rate timer.
- `adc_miso_i`  in  1: ADC serial data.
- `adc_cs_n_o`  out  1: ADC chip select, active-low.
- `adc_sclk_o`  out  1: ADC serial clock, idles low.
- `data_o`  out  16: last completed sample.
- `data_av_sync`  out  1: one-cycle strobe; `data_o` is new in the same cycle.
- `busy_o`  out  1: high when the FSM is not in IDLE.
- `overrun_o`  out  1: sticky dropped-request flag.

## Operation
- **Reset values:** `adc_cs_n_o`=1, `adc_sclk_o`=0, `data_o`=0, `data_av_sync`=0, `busy_o`=0, `overrun_o`=0, FSM in IDLE, timer=0.
- **Reset mid-conversion:** aborts the conversion. Pins return to idle at the next edge; no strobe is issued.
- **Timer:**
  - While `enable_i`=1, the timer counts 0..SAMPLE_PERIOD-1 and wraps.
  - A tick is asserted in the cycle the timer equals SAMPLE_PERIOD-1.
  - While `enable_i`=0, the timer is held at 0 and no ticks occur.
- **FSM states:** IDLE, CS_SETUP, SHIFT, CS_HOLD, DONE.
- **IDLE:** a tick moves to CS_SETUP. `adc_cs_n_o` goes 0 at that edge.
- **CS_SETUP:** lasts CLK_DIV cycles, then moves to SHIFT with `adc_sclk_o` going 1.
- **SHIFT:**
  - `adc_sclk_o` toggles every CLK_DIV cycles.
  - The shift register captures `adc_miso_i` at each clk edge where SCLK goes 0→1. The first capture is the MSB; bits shift left.
  - After the 16th falling SCLK edge, move to CS_HOLD.
- **CS_HOLD:** lasts CLK_DIV cycles with SCLK=0, then moves to DONE with `adc_cs_n_o` going 1.
- **DONE:** lasts one cycle.
  - `data_o` is loaded from the shift register and `data_av_sync`=1 in the same cycle.
  - The FSM then returns to IDLE.
- **Overrun:**
  - A tick arriving while the FSM is not in IDLE is dropped; the current conversion continues unaffected.
  - `overrun_o` is set at the next edge and stays set until `rst_i`=1 or `enable_i`=0.
- **Deasserting `enable_i` mid-conversion:** the conversion completes normally and still strobes.
- **Output holding:** `data_o` holds its value between strobes and is never partially updated.

## Timing
- Tick at cycle T:
  - `adc_cs_n_o` falls at T+1.
  - SCLK rising edge k (k=0..15) occurs at T+1+CLK_DIV+2k·CLK_DIV.
  - Last SCLK falling edge at T+1+32·CLK_DIV.
  - `adc_cs_n_o` rises and `data_av_sync`=1 at T+1+33·CLK_DIV.
  - IDLE again at T+2+33·CLK_DIV.
- Defaults (CLK_DIV=4): strobe at T+133.
- Overrun-free operation requires SAMPLE_PERIOD ≥ 33·CLK_DIV+2.
- First tick occurs SAMPLE_PERIOD cycles after `enable_i` rises, i.e. the timer reaches SAMPLE_PERIOD-1 in the SAMPLE_PERIOD-th enabled cycle.
- `busy_o` is high from T+1 through T+1+33·CLK_DIV inclusive.
- `data_av_sync` is never high in two consecutive cycles.

## Configuration
- **Macro:** `ADC_SPI_SAMPLER_MISO_SYNC_EN`.
- **Defined:**
  - `adc_miso_i` passes through a 2-flop synchronizer reset to 0.
  - Capture happens 2 clk cycles after each SCLK rising edge, still within the high phase; CLK_DIV ≥3 is required.
  - Shift, strobe timing and all other behaviour are unchanged.
- **Undefined:** `adc_miso_i` is captured directly at the SCLK rising edge; CLK_DIV ≥1 is legal.

## Test plan
- **Single conversion:** defaults, ADC model drives 0xA5C3 MSB-first (changing on SCLK fall), `enable_i`=1 → exactly 16 SCLK pulses inside the CS-low window, `data_o`=0xA5C3 with a one-cycle `data_av_sync` 133 cycles after the tick.
- **Back-to-back samples:** model alternates 0x0001 / 0xFFFF over 3 periods → strobes exactly 200 cycles apart, data in order, `overrun_o`=0.
- **Overrun:** SAMPLE_PERIOD=100, CLK_DIV=4 → `overrun_o`=1 after the 2nd tick. Every other tick is dropped, conversions still return correct data, and `enable_i`=0 clears the flag.
- **Reset mid-SHIFT:** `rst_i` asserted after the 5th SCLK rise → next edge shows `adc_cs_n_o`=1, `adc_sclk_o`=0, `data_o`=0, no strobe; a later conversion is correct.
- **Enable drop mid-conversion:** `enable_i`=0 during SHIFT → conversion finishes with a strobe, then no further CS activity while disabled.
- **Compiled with `ADC_SPI_SAMPLER_MISO_SYNC_EN`, CLK_DIV=3:** pattern 0x8001 read correctly, strobe at T+1+99.
